rx_selio_align_ctrl: RTL and testbench

RX_SELIO_ALIGN_CTRL -- requirements
Module: rx_selio_align_ctrl

---
 rtl/rx_selio_align_ctrl_if.sv | 26 ++
 rtl/rx_selio_align_ctrl.sv | 147 ++++++++++++++
 tb/tb_rx_selio_align_ctrl.sv | 213 +++++++++++++++++++++
 3 files changed

// File: rtl/rx_selio_align_ctrl_if.sv
// Control/status bundle between the SelectIO word-alignment controller and
// its environment (deserializer, register file).
interface rx_selio_align_ctrl_if #(
  parameter int unsigned DATA_WIDTH = 8
);
  logic                  start;
  logic [DATA_WIDTH-1:0] train_pattern;
  logic [DATA_WIDTH-1:0] rx_data;
  logic                  rx_data_valid;
  logic                  bitslip;
  logic                  locked;
  logic                  fail;
  logic                  busy;
  logic [3:0]            slip_count;
  logic [15:0]           err_count;

  modport slave (
    input  start, train_pattern, rx_data, rx_data_valid,
    output bitslip, locked, fail, busy, slip_count, err_count
  );

  modport master (
    output start, train_pattern, rx_data, rx_data_valid,
    input  bitslip, locked, fail, busy, slip_count, err_count
  );
endinterface

// File: rtl/rx_selio_align_ctrl.sv
// SelectIO receive word aligner: compares deserialized words against a training
// pattern, issues bitslip pulses until lock, and monitors lock for loss.
module rx_selio_align_ctrl #(
  parameter int unsigned DATA_WIDTH    = 8,
  parameter int unsigned SETTLE_CYCLES = 4,
  parameter int unsigned MATCH_COUNT   = 16,
  parameter int unsigned LOSS_COUNT    = 4
) (
  input  logic                 ACLK,
  input  logic                 ARESET,
  rx_selio_align_ctrl_if.slave bus
);
  localparam int unsigned MW = $clog2(MATCH_COUNT + 1);
  localparam int unsigned SW = $clog2(SETTLE_CYCLES + 1);
  localparam int unsigned LW = $clog2(LOSS_COUNT + 1);

  localparam logic [MW-1:0] MATCH_LAST  = MW'(MATCH_COUNT - 1);
  localparam logic [SW-1:0] SETTLE_LAST = SW'(SETTLE_CYCLES - 1);
  localparam logic [LW-1:0] LOSS_LAST   = LW'(LOSS_COUNT - 1);
  localparam logic [3:0]    SLIP_LAST   = 4'(DATA_WIDTH - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_CHECK, S_SLIP, S_SETTLE, S_LOCKED, S_FAIL
  } state_t;

  state_t                state_q;
  logic [DATA_WIDTH-1:0] pattern_q;
  logic [MW-1:0]         match_cnt_q;
  logic [SW-1:0]         settle_cnt_q;
  logic [LW-1:0]         miss_cnt_q;
  logic [3:0]            slip_count_q;
  logic [15:0]           err_count_q;
  logic [15:0]           err_count_d;
  logic                  bitslip_q;
  logic                  locked_q;
  logic                  fail_q;
  logic                  busy_q;
  logic                  restart;
  logic                  word_match;

  // Start is only honoured where no training is in progress.
  assign restart    = bus.start && (state_q == S_IDLE || state_q == S_FAIL ||
                                    state_q == S_LOCKED);
  assign word_match = (bus.rx_data == pattern_q);

  always_comb begin
    err_count_d = (err_count_q == '1) ? err_count_q : err_count_q + 16'd1;
  end

  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      state_q      <= S_IDLE;
      pattern_q    <= '0;
      match_cnt_q  <= '0;
      settle_cnt_q <= '0;
      miss_cnt_q   <= '0;
      slip_count_q <= '0;
      err_count_q  <= '0;
      bitslip_q    <= 1'b0;
      locked_q     <= 1'b0;
      fail_q       <= 1'b0;
      busy_q       <= 1'b0;
    end else begin
      bitslip_q <= 1'b0;
      if (restart) begin
        state_q      <= S_CHECK;
        pattern_q    <= bus.train_pattern;
        match_cnt_q  <= '0;
        miss_cnt_q   <= '0;
        slip_count_q <= '0;
        err_count_q  <= '0;
        locked_q     <= 1'b0;
        fail_q       <= 1'b0;
        busy_q       <= 1'b1;
      end else begin
        case (state_q)
          S_CHECK: begin
            if (bus.rx_data_valid) begin
              if (word_match) begin
                if (match_cnt_q == MATCH_LAST) begin
                  state_q     <= S_LOCKED;
                  match_cnt_q <= '0;
                  miss_cnt_q  <= '0;
                  locked_q    <= 1'b1;
                  busy_q      <= 1'b0;
                end else begin
                  match_cnt_q <= match_cnt_q + 1'b1;
                end
              end else if (slip_count_q == SLIP_LAST) begin
                state_q     <= S_FAIL;
                match_cnt_q <= '0;
                fail_q      <= 1'b1;
                busy_q      <= 1'b0;
              end else begin
                state_q      <= S_SLIP;
                match_cnt_q  <= '0;
                slip_count_q <= slip_count_q + 4'd1;
                bitslip_q    <= 1'b1;
              end
            end
          end
          S_SLIP: begin
            state_q      <= S_SETTLE;
            settle_cnt_q <= '0;
          end
          S_SETTLE: begin
            if (settle_cnt_q == SETTLE_LAST) begin
              state_q      <= S_CHECK;
              settle_cnt_q <= '0;
              match_cnt_q  <= '0;
            end else begin
              settle_cnt_q <= settle_cnt_q + 1'b1;
            end
          end
          S_LOCKED: begin
            if (bus.rx_data_valid) begin
              if (word_match) begin
                miss_cnt_q <= '0;
              end else begin
                err_count_q <= err_count_d;
                if (miss_cnt_q == LOSS_LAST) begin
                  // Loss of lock retrains from scratch but keeps the error history.
                  state_q      <= S_CHECK;
                  miss_cnt_q   <= '0;
                  match_cnt_q  <= '0;
                  slip_count_q <= '0;
                  locked_q     <= 1'b0;
                  busy_q       <= 1'b1;
                end else begin
                  miss_cnt_q <= miss_cnt_q + 1'b1;
                end
              end
            end
          end
          default: ;
        endcase
      end
    end
  end

  assign bus.bitslip    = bitslip_q;
  assign bus.locked     = locked_q;
  assign bus.fail       = fail_q;
  assign bus.busy       = busy_q;
  assign bus.slip_count = slip_count_q;
  assign bus.err_count  = err_count_q;
endmodule

// File: tb/tb_rx_selio_align_ctrl.sv
// Directed bench for rx_selio_align_ctrl with a rotating deserializer model.
module tb_rx_selio_align_ctrl;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  int   pulses = 0;
  int   last_pulse = -100;
  logic prev_slip = 1'b0;

  logic       model_en = 1'b0;
  int         pos = 0;
  logic [7:0] drv_data = 8'h00;
  logic [7:0] pat = 8'h5C;

  rx_selio_align_ctrl_if #(.DATA_WIDTH(8)) bus ();

  rx_selio_align_ctrl #(
    .DATA_WIDTH(8), .SETTLE_CYCLES(4), .MATCH_COUNT(16), .LOSS_COUNT(4)
  ) dut (
    .ACLK(clk), .ARESET(rst), .bus(bus)
  );

  always #5 clk = ~clk;

  function automatic logic [7:0] rotl(input logic [7:0] v, input int n);
    logic [15:0] w;
    w = {v, v} << (n % 8);
    return w[15:8];
  endfunction

  assign bus.rx_data = model_en ? rotl(pat, pos) : drv_data;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (bus.bitslip) pos <= (pos + 1) % 8;
  end

  // Pulse width and spacing monitor.
  always @(negedge clk) begin
    if (bus.bitslip) begin
      chk("slip_width", {31'd0, prev_slip}, 32'd0);
      chk("slip_gap", {31'd0, (cyc - last_pulse) >= 6}, 32'd1);
      last_pulse = cyc;
      pulses++;
    end
    prev_slip = bus.bitslip;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
  endtask

  task automatic wait_locked(input string tag, input int budget);
    for (int i = 0; i < budget && !bus.locked; i++) tick();
    chk(tag, {31'd0, bus.locked}, 32'd1);
  endtask

  initial begin
    int p0;
    bus.start         = 1'b0;
    bus.train_pattern = 8'h5C;
    bus.rx_data_valid = 1'b0;
    do_reset();
    chk("rst_locked", {31'd0, bus.locked}, 32'd0);
    chk("rst_fail", {31'd0, bus.fail}, 32'd0);
    chk("rst_busy", {31'd0, bus.busy}, 32'd0);
    chk("rst_slipcnt", {28'd0, bus.slip_count}, 32'd0);
    chk("rst_errcnt", {16'd0, bus.err_count}, 32'd0);

    // Aligned stream: lock at cycle 17 with no slips.
    drv_data = 8'h5C;
    bus.rx_data_valid = 1'b1;
    bus.start = 1'b1;
    p0 = pulses;
    for (int n = 1; n <= 17; n++) begin
      tick();
      bus.start = 1'b0;
      if (n == 1)  chk("a_busy_c1", {31'd0, bus.busy}, 32'd1);
      if (n == 16) chk("a_locked_c16", {31'd0, bus.locked}, 32'd0);
    end
    chk("a_locked_c17", {31'd0, bus.locked}, 32'd1);
    chk("a_busy_lock", {31'd0, bus.busy}, 32'd0);
    chk("a_slipcnt", {28'd0, bus.slip_count}, 32'd0);
    chk("a_pulses", pulses - p0, 32'd0);

    // Deserializer 3 positions off.
    do_reset();
    pos = 5;
    model_en = 1'b1;
    p0 = pulses;
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    wait_locked("b_lock", 200);
    chk("b_slipcnt", {28'd0, bus.slip_count}, 32'd3);
    chk("b_pulses", pulses - p0, 32'd3);
    model_en = 1'b0;

    // No valid alignment exists.
    do_reset();
    drv_data = 8'h00;
    p0 = pulses;
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    for (int i = 0; i < 200 && !bus.fail; i++) tick();
    chk("c_fail", {31'd0, bus.fail}, 32'd1);
    tick();
    tick();
    chk("c_pulses", pulses - p0, 32'd7);
    chk("c_locked", {31'd0, bus.locked}, 32'd0);
    chk("c_busy", {31'd0, bus.busy}, 32'd0);
    chk("c_slipcnt", {28'd0, bus.slip_count}, 32'd7);
    bus.start = 1'b1;
    drv_data = 8'h5C;
    tick();
    bus.start = 1'b0;
    chk("c_restart_fail", {31'd0, bus.fail}, 32'd0);
    chk("c_restart_slip", {28'd0, bus.slip_count}, 32'd0);
    chk("c_restart_busy", {31'd0, bus.busy}, 32'd1);

    // Errors while locked, then loss of lock.
    wait_locked("d_lock", 40);
    drv_data = 8'hA5;
    tick(); tick(); tick();
    drv_data = 8'h5C;
    tick();
    chk("d_locked_hold", {31'd0, bus.locked}, 32'd1);
    chk("d_err3", {16'd0, bus.err_count}, 32'd3);
    drv_data = 8'hA5;
    tick(); tick(); tick();
    chk("d_locked_3miss", {31'd0, bus.locked}, 32'd1);
    drv_data = 8'h5C;
    bus.rx_data_valid = 1'b1;
    drv_data = 8'hA5;
    tick();
    drv_data = 8'h5C;
    chk("d_lost", {31'd0, bus.locked}, 32'd0);
    chk("d_lost_busy", {31'd0, bus.busy}, 32'd1);
    chk("d_err7", {16'd0, bus.err_count}, 32'd7);
    // Start and pattern changes during training are ignored.
    bus.train_pattern = 8'h33;
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    wait_locked("d_relock", 40);
    chk("d_err_kept", {16'd0, bus.err_count}, 32'd7);
    bus.train_pattern = 8'h5C;
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    chk("d_restart_err", {16'd0, bus.err_count}, 32'd0);
    chk("d_restart_locked", {31'd0, bus.locked}, 32'd0);

    // Reset in SETTLE after two slips, with start asserted alongside.
    do_reset();
    drv_data = 8'h00;
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    for (int i = 0; i < 100 && !(bus.bitslip && bus.slip_count == 4'd2); i++) tick();
    chk("e_second_slip", {28'd0, bus.slip_count}, 32'd2);
    tick();
    tick();
    rst = 1'b1;
    bus.start = 1'b1;
    tick();
    rst = 1'b0;
    bus.start = 1'b0;
    chk("e_busy", {31'd0, bus.busy}, 32'd0);
    chk("e_slipcnt", {28'd0, bus.slip_count}, 32'd0);
    chk("e_bitslip", {31'd0, bus.bitslip}, 32'd0);
    chk("e_locked_fail", {30'd0, bus.locked, bus.fail}, 32'd0);
    p0 = pulses;
    for (int i = 0; i < 20; i++) tick();
    chk("e_idle_pulses", pulses - p0, 32'd0);
    chk("e_idle_busy", {31'd0, bus.busy}, 32'd0);

    // Valid toggling: lock at cycle 32.
    do_reset();
    drv_data = 8'h5C;
    bus.rx_data_valid = 1'b0;
    bus.start = 1'b1;
    for (int n = 1; n <= 32; n++) begin
      tick();
      bus.start = 1'b0;
      bus.rx_data_valid = (n % 2 == 1);
      if (n == 31) chk("f_locked_c31", {31'd0, bus.locked}, 32'd0);
    end
    chk("f_locked_c32", {31'd0, bus.locked}, 32'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
